// File: rtl/adder_share_arbiter.sv
// Round-robin front end that shares one external pipelined adder among NREQ requesters.
// Define ADDER_ARB_STATS_EN to build the saturating per-requester grant counters.
module adder_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_a,
    input  logic [NREQ*N-1:0]  req_b,
    input  logic [NREQ-1:0]    req_cin,
    output logic [N-1:0]       add_a,
    output logic [N-1:0]       add_b,
    output logic               add_cin,
    input  logic [N-1:0]       add_s,
    input  logic               add_cout,
    output logic [NREQ-1:0]    resp_valid,
    output logic [N-1:0]       resp_s,
    output logic               resp_cout,
    output logic [NREQ*16-1:0] stat_grants
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]         r_rr_ptr;
    logic [N-1:0]          r_add_a;
    logic [N-1:0]          r_add_b;
    logic                  r_add_cin;
    logic [LAT:0]          r_tag_valid;
    logic [LAT:0][PW-1:0]  r_tag_id;

    logic                  w_found;
    logic [PW-1:0]         w_gnt_id;
    logic [NREQ-1:0]       w_gnt_onehot;
    logic                  w_accept;
    logic [PW-1:0]         w_ptr_next;
    logic [N-1:0]          w_sel_a;
    logic [N-1:0]          w_sel_b;
    logic                  w_sel_cin;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return PW'(sum);
    endfunction

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && req_valid[wrap_idx(r_rr_ptr, off)]) begin
                w_found  = 1'b1;
                w_gnt_id = wrap_idx(r_rr_ptr, off);
            end
        end
    end

    assign w_accept = w_found && !rst;

    always_comb begin
        w_gnt_onehot = '0;
        if (w_accept) begin
            w_gnt_onehot[w_gnt_id] = 1'b1;
        end
    end

    assign req_ready  = w_gnt_onehot;
    assign w_ptr_next = (w_gnt_id == PW'(NREQ - 1)) ? '0 : w_gnt_id + PW'(1);
    assign w_sel_a    = req_a[w_gnt_id * N +: N];
    assign w_sel_b    = req_b[w_gnt_id * N +: N];
    assign w_sel_cin  = req_cin[w_gnt_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr  <= w_ptr_next;
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_add_cin <= w_sel_cin;
        end
    end

    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign add_cin = r_add_cin;

    // Stage 0 loads alongside the operand register, so the tag reaches stage LAT
    // in the same cycle the adder presents the matching sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid <= '0;
            r_tag_id    <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[LAT-1:0], w_accept};
            r_tag_id    <= {r_tag_id[LAT-1:0], w_gnt_id};
        end
    end

    always_comb begin
        resp_valid = '0;
        if (r_tag_valid[LAT]) begin
            resp_valid[r_tag_id[LAT]] = 1'b1;
        end
    end

    assign resp_s    = add_s;
    assign resp_cout = add_cout;

`ifdef ADDER_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_gnt_id == PW'(gi)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_grants[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed/random self-checking bench for adder_share_arbiter with a behavioural 2-stage adder.
`timescale 1ns/1ps
module tb_adder_share_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*N-1:0]     req_a;
    logic [NREQ*N-1:0]     req_b;
    logic [NREQ-1:0]       req_cin = '0;
    logic [N-1:0]          add_a;
    logic [N-1:0]          add_b;
    logic                  add_cin;
    logic [N-1:0]          add_s;
    logic                  add_cout;
    logic [NREQ-1:0]       resp_valid;
    logic [N-1:0]          resp_s;
    logic                  resp_cout;
    logic [NREQ*16-1:0]    stat_grants;

    logic [N-1:0] op_a [NREQ];
    logic [N-1:0] op_b [NREQ];
    logic [N:0]   r_add_p0 = '0;
    logic [N:0]   r_add_p1 = '0;

    int         errors = 0;
    int         checks = 0;
    int         q_id[$];
    logic [N:0] q_sum[$];
    int         last_gnt;
    int         exp_id;
    logic [N:0] exp_sum;
    int         resp_cnt;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
            assign req_a[gi*N +: N] = op_a[gi];
            assign req_b[gi*N +: N] = op_b[gi];
        end
    endgenerate

    // Adder with LAT=2 register stages behind the arbiter's operand registers.
    always @(posedge clk) begin
        r_add_p0 <= {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
        r_add_p1 <= r_add_p0;
    end
    assign {add_cout, add_s} = r_add_p1;

    adder_share_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .resp_valid(resp_valid), .resp_s(resp_s), .resp_cout(resp_cout),
        .stat_grants(stat_grants)
    );

    // Records the accept about to happen at the next edge, then advances past that edge.
    task automatic step();
        #1;
        last_gnt = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                last_gnt = i;
                q_id.push_back(i);
                q_sum.push_back({1'b0, op_a[i]} + {1'b0, op_b[i]} + {{N{1'b0}}, req_cin[i]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_id.delete();
        q_sum.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        rst = 1'b1;
        req_valid = '1;
        req_cin = '1;
        step();
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_ready: got %b, expected 0000", req_ready);
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            errors++; $display("FAIL reset_operands: got a=%h b=%h cin=%b, expected zeros", add_a, add_b, add_cin);
        end
        checks++;
        if (resp_valid !== '0) begin
            errors++; $display("FAIL reset_resp_valid: got %b, expected 0000", resp_valid);
        end
        checks++;
        if (stat_grants !== '0) begin
            errors++; $display("FAIL reset_stats: got %h, expected 0", stat_grants);
        end
        step();
        rst = 1'b0;
        req_valid = '0;
        req_cin = '0;
        clear_q();
    endtask

    task automatic test_single_add();
        logic [NREQ-1:0] exp_rv;
        req_valid = 4'b0100;
        op_a[2] = 32'd283;
        op_b[2] = 32'd50;
        req_cin = '0;
        step();
        req_valid = '0;
        checks++;
        if (last_gnt !== 2) begin
            errors++; $display("FAIL single_grant: got %0d, expected 2", last_gnt);
        end
        checks++;
        if (add_a !== 32'd283 || add_b !== 32'd50 || add_cin !== 1'b0) begin
            errors++; $display("FAIL single_issue: got a=%0d b=%0d cin=%b, expected 283 50 0", add_a, add_b, add_cin);
        end
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c > 0) step();
            exp_rv = (c == LAT) ? 4'b0100 : 4'b0000;
            checks++;
            if (resp_valid !== exp_rv) begin
                errors++; $display("FAIL single_resp_valid c=%0d: got %b, expected %b", c, resp_valid, exp_rv);
            end
            if (c == LAT) begin
                checks++;
                if (resp_s !== 32'd333 || resp_cout !== 1'b0) begin
                    errors++; $display("FAIL single_sum: got s=%0d cout=%b, expected 333 0", resp_s, resp_cout);
                end
                $display("single add: id=2 s=%0d cout=%b", resp_s, resp_cout);
            end
        end
        clear_q();
    endtask

    task automatic test_carry();
        int         vid [3] = '{0, 3, 1};
        logic [N-1:0] va [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [N-1:0] vb [3] = '{32'h1, 32'h0, 32'h1};
        logic         vc [3] = '{1'b1, 1'b1, 1'b0};
        logic [N-1:0] es [3] = '{32'h1, 32'h0, 32'h80000000};
        logic         ec [3] = '{1'b1, 1'b1, 1'b0};
        for (int v = 0; v < 3; v++) begin
            req_valid = '0;
            req_cin = '0;
            req_valid[vid[v]] = 1'b1;
            op_a[vid[v]] = va[v];
            op_b[vid[v]] = vb[v];
            req_cin[vid[v]] = vc[v];
            step();
            req_valid = '0;
            for (int c = 1; c <= LAT; c++) step();
            checks++;
            if (resp_valid !== (NREQ'(1) << vid[v]) || resp_s !== es[v] || resp_cout !== ec[v]) begin
                errors++; $display("FAIL carry_%0d: got valid=%b s=%h cout=%b, expected valid=%b s=%h cout=%b",
                                   v, resp_valid, resp_s, resp_cout, NREQ'(1) << vid[v], es[v], ec[v]);
            end
            $display("carry vector %0d: id=%0d s=%h cout=%b", v, vid[v], resp_s, resp_cout);
        end
        req_cin = '0;
        clear_q();
    endtask

    task automatic test_back_to_back();
        resp_cnt = 0;
        req_valid = 4'b0010;
        for (int c = 0; c < 6 + LAT + 1; c++) begin
            if (c < 6) begin
                op_a[1] = 32'h0100_0000 * c + 32'd7;
                op_b[1] = 32'hF000_0000 + c;
                req_cin[1] = c[0];
            end else begin
                req_valid = '0;
            end
            step();
            if (c < 6) begin
                checks++;
                if (last_gnt !== 1) begin
                    errors++; $display("FAIL b2b_grant c=%0d: got %0d, expected 1", c, last_gnt);
                end
            end
            if (resp_valid !== '0) begin
                resp_cnt++;
                checks++;
                if (q_id.size() == 0) begin
                    errors++; $display("FAIL b2b_resp: unexpected resp_valid=%b", resp_valid);
                end else begin
                    exp_id = q_id.pop_front();
                    exp_sum = q_sum.pop_front();
                    if (resp_valid !== (NREQ'(1) << exp_id) || {resp_cout, resp_s} !== exp_sum) begin
                        errors++; $display("FAIL b2b_resp: got valid=%b sum=%h, expected valid=%b sum=%h",
                                           resp_valid, {resp_cout, resp_s}, NREQ'(1) << exp_id, exp_sum);
                    end
                    $display("b2b resp: id=%0d sum=%h", exp_id, {resp_cout, resp_s});
                end
            end
        end
        checks++;
        if (resp_cnt !== 6 || q_id.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d responses, %0d outstanding, expected 6 and 0", resp_cnt, q_id.size());
        end
        req_cin = '0;
        clear_q();
    endtask

    task automatic test_contention();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_q();
        resp_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        req_cin = 4'b1010;
        for (int c = 0; c < 12 + LAT + 1; c++) begin
            req_valid = (c < 12) ? 4'b1111 : 4'b0000;
            step();
            if (c < 12) begin
                checks++;
                if (last_gnt !== c % NREQ) begin
                    errors++; $display("FAIL contention_grant c=%0d: got %0d, expected %0d", c, last_gnt, c % NREQ);
                end
                if (last_gnt >= 0) begin
                    op_a[last_gnt] = $urandom;
                    op_b[last_gnt] = $urandom;
                end
            end
            if (resp_valid !== '0) begin
                resp_cnt++;
                checks++;
                if (q_id.size() == 0) begin
                    errors++; $display("FAIL contention_resp: unexpected resp_valid=%b", resp_valid);
                end else begin
                    exp_id = q_id.pop_front();
                    exp_sum = q_sum.pop_front();
                    if (resp_valid !== (NREQ'(1) << exp_id) || {resp_cout, resp_s} !== exp_sum) begin
                        errors++; $display("FAIL contention_resp: got valid=%b sum=%h, expected valid=%b sum=%h",
                                           resp_valid, {resp_cout, resp_s}, NREQ'(1) << exp_id, exp_sum);
                    end
                    $display("contention resp: id=%0d sum=%h", exp_id, {resp_cout, resp_s});
                end
            end
        end
        checks++;
        if (resp_cnt !== 12 || q_id.size() != 0) begin
            errors++; $display("FAIL contention_count: got %0d responses, %0d outstanding, expected 12 and 0", resp_cnt, q_id.size());
        end
        req_cin = '0;
        clear_q();
    endtask

    task automatic test_reset_midflight();
        req_cin = '0;
        req_valid = 4'b0001;
        op_a[0] = 32'd10;
        op_b[0] = 32'd20;
        step();
        checks++;
        if (last_gnt !== 0) begin
            errors++; $display("FAIL midflight_grant0: got %0d, expected 0", last_gnt);
        end
        req_valid = 4'b0010;
        op_a[1] = 32'd5;
        op_b[1] = 32'd6;
        step();
        checks++;
        if (last_gnt !== 1) begin
            errors++; $display("FAIL midflight_grant1: got %0d, expected 1", last_gnt);
        end
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_q();
        for (int c = 0; c <= LAT + 2; c++) begin
            checks++;
            if (resp_valid !== '0) begin
                errors++; $display("FAIL midflight_no_resp c=%0d: got %b, expected 0000", c, resp_valid);
            end
            step();
        end
        req_valid = 4'b1111;
        step();
        req_valid = '0;
        checks++;
        if (last_gnt !== 0) begin
            errors++; $display("FAIL midflight_ptr: got grant %0d, expected 0", last_gnt);
        end
        for (int c = 0; c <= LAT; c++) step();
        clear_q();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend = '0;
        int gen = 0;
        int issued = 0;
        int cyc = 0;
        resp_cnt = 0;
        clear_q();
        while ((issued < 200 || cyc < 200 + LAT + 2 && q_id.size() != 0) && cyc < 3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && gen < 200 && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    gen++;
                    op_a[i] = $urandom;
                    op_b[i] = $urandom;
                    req_cin[i] = 1'($urandom_range(0, 1));
                end
            end
            req_valid = pend;
            #1;
            checks++;
            if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0 || (req_valid != '0 && req_ready == '0)) begin
                errors++; $display("FAIL rand_grant: got ready=%b for valid=%b", req_ready, req_valid);
            end
            step();
            if (last_gnt >= 0) begin
                pend[last_gnt] = 1'b0;
                issued++;
            end
            if (resp_valid !== '0) begin
                resp_cnt++;
                checks++;
                if (q_id.size() == 0) begin
                    errors++; $display("FAIL rand_resp: unexpected resp_valid=%b", resp_valid);
                end else begin
                    exp_id = q_id.pop_front();
                    exp_sum = q_sum.pop_front();
                    if (resp_valid !== (NREQ'(1) << exp_id) || {resp_cout, resp_s} !== exp_sum) begin
                        errors++; $display("FAIL rand_resp: got valid=%b sum=%h, expected valid=%b sum=%h",
                                           resp_valid, {resp_cout, resp_s}, NREQ'(1) << exp_id, exp_sum);
                    end
                    $display("rand resp %0d: id=%0d sum=%h", resp_cnt, exp_id, {resp_cout, resp_s});
                end
            end
            cyc++;
        end
        req_valid = '0;
        for (int c = 0; c <= LAT + 1; c++) begin
            step();
            if (resp_valid !== '0) begin
                resp_cnt++;
                checks++;
                if (q_id.size() == 0) begin
                    errors++; $display("FAIL rand_drain: unexpected resp_valid=%b", resp_valid);
                end else begin
                    exp_id = q_id.pop_front();
                    exp_sum = q_sum.pop_front();
                    if (resp_valid !== (NREQ'(1) << exp_id) || {resp_cout, resp_s} !== exp_sum) begin
                        errors++; $display("FAIL rand_drain: got valid=%b sum=%h, expected valid=%b sum=%h",
                                           resp_valid, {resp_cout, resp_s}, NREQ'(1) << exp_id, exp_sum);
                    end
                end
            end
        end
        checks++;
        if (issued !== 200) begin
            errors++; $display("FAIL rand_issue: got %0d accepts within budget, expected 200", issued);
        end
        checks++;
        if (resp_cnt !== 200 || q_id.size() != 0) begin
            errors++; $display("FAIL rand_count: got %0d responses, %0d outstanding, expected 200 and 0", resp_cnt, q_id.size());
        end
        req_cin = '0;
        clear_q();
    endtask

    task automatic test_stats();
`ifdef ADDER_ARB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) step();
        checks++;
        if (stat_grants !== {16'd0, 16'd0, 16'd5, 16'd0}) begin
            errors++; $display("FAIL stats_count5: got %h, expected %h", stat_grants, {16'd0, 16'd0, 16'd5, 16'd0});
        end
        for (int c = 5; c < 70000; c++) begin
            step();
            if (c % 1000 == 0) clear_q();
        end
        req_valid = '0;
        checks++;
        if (stat_grants !== {16'd0, 16'd0, 16'hFFFF, 16'd0}) begin
            errors++; $display("FAIL stats_saturate: got %h, expected %h", stat_grants, {16'd0, 16'd0, 16'hFFFF, 16'd0});
        end
        $display("stats: 70000 accepts by requester 1, counters=%h", stat_grants);
        clear_q();
`else
        checks++;
        if (stat_grants !== '0) begin
            errors++; $display("FAIL stats_off: got %h, expected 0", stat_grants);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single_add();
        test_carry();
        test_back_to_back();
        test_contention();
        test_reset_midflight();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
